interrupt_arbiter: RTL and testbench
====================================

INTERRUPT_ARBITER -- requirements
Module: interrupt_arbiter

Interface
REQ-001 Parameter N_IRQ, default 8: number of interrupt channels, legal range 2..32.
REQ-002 Parameter ID_W, default 3: width of the channel index, equal to clog2(N_IRQ).
REQ-003 Parameter EDGE_MASK, default all ones: per channel, 1 = rising-edge triggered, 0 = level triggered.
REQ-004 Parameter RR_MODE, default 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-005 Parameter MASK_RST, default 0: value loaded into mask on reset.
REQ-006 One clock; reset is synchronous and active-low.
REQ-007 clk  in  1  main clock; all state changes on its rising edge.
REQ-008 rst  in  1  synchronous reset, active-low (0 = reset).
REQ-009 irq_in  in  N_IRQ  interrupt sources, synchronous to clk.
REQ-010 ir_en  in  1  global interrupt enable from CP0.
REQ-011 stall  in  1  pipeline stall (ram/rom stall OR); while 1, ir_ack is ignored.
REQ-012 ir_ack  in  1  core accepted the request (jump taken).
REQ-013 ir_done  in  1  handler finished (ERET retired).
REQ-014 mask_wen  in  1  write enable for the mask.
REQ-015 mask_din  in  N_IRQ  new mask value; 1 = channel enabled.
REQ-016 ovf_clr  in  1  clears all overflow flags.
REQ-017 ir  out  1  interrupt request to the core.
REQ-018 ir_id  out  ID_W  index of the requesting or in-service channel.
REQ-019 in_service  out  1  a handler is running.
REQ-020 pending  out  N_IRQ  registered pending bits.
REQ-021 mask  out  N_IRQ  current mask.
REQ-022 ovf  out  N_IRQ  sticky flags: an edge was lost because the channel was already pending.

Function
REQ-023 Edge channels: prev register; pending set when irq_in=1 and prev=0, visible after that clock edge; cleared only by a stall-free ir_ack with ir_id equal to that channel.
REQ-024 Edge channel set and clear on the same channel in the same cycle: set wins, pending stays 1.
REQ-025 Edge channel edge while pending already 1 and not being cleared that cycle: ovf bit set; ovf_clr clears all bits; a new overflow in the same cycle as ovf_clr wins.
REQ-026 Level channels: pending equals irq_in registered one cycle; ir_ack does not clear them.
REQ-027 mask_wen writes mask_din at the clock edge; the new value takes effect for arbitration in the following cycle.
REQ-028 Eligible vector: pending AND mask, considered only when ir_en=1.
REQ-029 FSM has three states: IDLE, REQ and SERVICE.
REQ-030 IDLE: when the eligible vector is nonzero, latch the winner into ir_id and go to REQ; ir=1 after that edge.
REQ-031 REQ: ir=1 and ir_id stays stable.
REQ-032 REQ, ir_ack=1 and stall=0: go to SERVICE, ir=0, in_service=1.
REQ-033 REQ, ir_en=0 or the latched channel no longer eligible (masked, or level source dropped): return to IDLE, ir=0, pending retained; ir_ack that cycle is ignored.
REQ-034 SERVICE: ir=0 and new requests are held pending (no nesting); ir_done=1 returns to IDLE, in_service=0, and arbitration resumes the next cycle.
REQ-035 ir_ack outside REQ and ir_done outside SERVICE are ignored.
REQ-036 RR_MODE=1: search starts at rr_ptr and wraps modulo N_IRQ; on an accepted ack rr_ptr becomes ir_id+1, with N_IRQ-1 wrapping to 0.
REQ-037 RR_MODE=0: rr_ptr is unused and the lowest eligible index wins.
REQ-038 Latency: irq_in edge sampled at clock edge k gives pending after edge k and ir=1 after edge k+1 (2 cycles, FSM idle, channel unmasked, ir_en=1).

Reset
REQ-039 rst=0 at a clock edge: state IDLE, ir=0, ir_id=0, in_service=0, pending=0, ovf=0, rr_ptr=0, mask=MASK_RST, prev loaded with irq_in (so a source held high through reset gives no edge).
REQ-040 Reset asserted in REQ or SERVICE: IDLE after that edge, and all prior pending interrupts are lost.

Verification
REQ-041 N_IRQ=8, mask=FF, ir_en=1, one-cycle pulse on irq_in[5] -> pending[5]=1 after edge k, ir=1 with ir_id=5 after edge k+1; ack -> pending[5]=0, in_service=1; ir_done -> IDLE.
REQ-042 RR_MODE=0, channels 2 and 6 pending together -> ir_id=2 first; after ir_done, ir_id=6. RR_MODE=1 with rr_ptr=3, same stimulus -> ir_id=6 first, then ir_id=2 (wrap).
REQ-043 In REQ, hold stall=1 with ir_ack=1 for 3 cycles -> ir stays 1 and ir_id unchanged; drop stall -> SERVICE next edge.
REQ-044 Second edge on edge channel 1 while pending[1]=1 -> ovf[1]=1 and pending[1] stays 1; ovf_clr -> ovf=0.
REQ-045 In REQ for channel 4, write mask bit 4 to 0 -> IDLE and ir=0 after two edges, pending[4] still 1; restore mask -> request re-raised.
REQ-046 rst=0 for one cycle while in SERVICE with irq_in[0] held high -> all outputs at reset values and no new pending[0] edge after release.

Source files
------------

// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter: per-channel edge/level capture, masking, fixed or round-robin
// selection, and a three-state request/service handshake towards the core.
module interrupt_arbiter #(
    parameter int              N_IRQ     = 8,
    parameter int              ID_W      = 3,
    parameter logic [N_IRQ-1:0] EDGE_MASK = '1,
    parameter int              RR_MODE   = 0,
    parameter logic [N_IRQ-1:0] MASK_RST  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             ir_en,
    input  logic             stall,
    input  logic             ir_ack,
    input  logic             ir_done,
    input  logic             mask_wen,
    input  logic [N_IRQ-1:0] mask_din,
    input  logic             ovf_clr,
    output logic             ir,
    output logic [ID_W-1:0]  ir_id,
    output logic             in_service,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] mask,
    output logic [N_IRQ-1:0] ovf,
    output logic [1:0]       dbg_state
);

    // Handshake: ir stays high with a stable ir_id until a cycle with ir_ack=1 and
    // stall=0 (accept) or until the latched channel stops being eligible (withdraw).
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  ir_id_q, ir_id_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] prev_q;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic [N_IRQ-1:0] ovf_q, ovf_d;

    logic [N_IRQ-1:0]   eligible;
    logic [N_IRQ-1:0]   id_onehot;
    logic               id_elig;
    logic [ID_W-1:0]    search_start;
    logic [2*N_IRQ-1:0] rot_wide;
    logic [N_IRQ-1:0]   rot;
    logic [ID_W-1:0]    offset;
    logic [ID_W:0]      win_sum;
    logic [ID_W-1:0]    winner;
    logic               ack_ok;
    logic [N_IRQ-1:0]   clr_vec;
    logic [N_IRQ-1:0]   rise;
    logic [N_IRQ-1:0]   new_ovf;

    assign eligible  = ir_en ? (pending_q & mask_q) : '0;
    assign id_onehot = N_IRQ'(1) << ir_id_q;
    assign id_elig   = |(eligible & id_onehot);

    // Rotate the eligible vector so the search origin sits at bit 0, pick the
    // lowest set bit, then add the origin back modulo N_IRQ.
    always_comb begin
        search_start = (RR_MODE != 0) ? rr_ptr_q : '0;
        rot_wide     = {eligible, eligible} >> search_start;
        rot          = rot_wide[N_IRQ-1:0];
        offset       = '0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                offset = ID_W'(k);
            end
        end
        win_sum = {1'b0, search_start} + {1'b0, offset};
        if (win_sum >= (ID_W+1)'(N_IRQ)) begin
            win_sum = win_sum - (ID_W+1)'(N_IRQ);
        end
        winner = win_sum[ID_W-1:0];
    end

    always_comb begin
        state_d  = state_q;
        ir_id_d  = ir_id_q;
        rr_ptr_d = rr_ptr_q;
        ack_ok   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|eligible) begin
                    ir_id_d = winner;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // Withdrawal takes precedence: an ack in the same cycle is ignored.
                if (!id_elig) begin
                    state_d = S_IDLE;
                end else if (ir_ack && !stall) begin
                    state_d = S_SERVICE;
                    ack_ok  = 1'b1;
                    if (RR_MODE != 0) begin
                        rr_ptr_d = (ir_id_q == ID_W'(N_IRQ - 1)) ? '0 : ir_id_q + ID_W'(1);
                    end
                end
            end
            S_SERVICE: begin
                if (ir_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        clr_vec   = ack_ok ? id_onehot : '0;
        rise      = irq_in & ~prev_q;
        // A fresh edge beats a simultaneous clear, so the channel stays pending.
        pending_d = (EDGE_MASK & (rise | (pending_q & ~clr_vec))) | (~EDGE_MASK & irq_in);
        new_ovf   = EDGE_MASK & rise & pending_q & ~clr_vec;
        ovf_d     = (ovf_clr ? '0 : ovf_q) | new_ovf;
        mask_d    = mask_wen ? mask_din : mask_q;
    end

    always_ff @(posedge clk) begin
        // prev tracks irq_in even in reset so a source held high gives no edge.
        prev_q <= irq_in;
        if (!rst) begin
            state_q   <= S_IDLE;
            ir_id_q   <= '0;
            rr_ptr_q  <= '0;
            pending_q <= '0;
            mask_q    <= MASK_RST;
            ovf_q     <= '0;
        end else begin
            state_q   <= state_d;
            ir_id_q   <= ir_id_d;
            rr_ptr_q  <= rr_ptr_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ir         = (state_q == S_REQ);
    assign in_service = (state_q == S_SERVICE);
    assign ir_id      = ir_id_q;
    assign pending    = pending_q;
    assign mask       = mask_q;
    assign ovf        = ovf_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Bench for interrupt_arbiter: a fixed-priority and a round-robin instance share
// the same stimulus; directed scenarios plus a random run against a reference model.
module tb_interrupt_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] irq_in;
    logic       ir_en, stall, ir_ack, ir_done, mask_wen, ovf_clr;
    logic [7:0] mask_din;

    // index 0: fixed priority, index 1: round-robin
    logic       ir_v[2];
    logic       svc_v[2];
    logic [2:0] id_v[2];
    logic [7:0] pend_v[2];
    logic [7:0] mask_v[2];
    logic [7:0] ovf_v[2];
    logic [1:0] st_v[2];

    logic [7:0] edge_chan = 8'h7F;

    int total = 0;
    int bad   = 0;

    interrupt_arbiter #(.N_IRQ(8), .ID_W(3), .EDGE_MASK(8'h7F), .RR_MODE(0), .MASK_RST(8'h00)) dut_fp (
        .clk(clk), .rst(rst), .irq_in(irq_in), .ir_en(ir_en), .stall(stall),
        .ir_ack(ir_ack), .ir_done(ir_done), .mask_wen(mask_wen), .mask_din(mask_din),
        .ovf_clr(ovf_clr), .ir(ir_v[0]), .ir_id(id_v[0]), .in_service(svc_v[0]),
        .pending(pend_v[0]), .mask(mask_v[0]), .ovf(ovf_v[0]), .dbg_state(st_v[0])
    );

    interrupt_arbiter #(.N_IRQ(8), .ID_W(3), .EDGE_MASK(8'h7F), .RR_MODE(1), .MASK_RST(8'h00)) dut_rr (
        .clk(clk), .rst(rst), .irq_in(irq_in), .ir_en(ir_en), .stall(stall),
        .ir_ack(ir_ack), .ir_done(ir_done), .mask_wen(mask_wen), .mask_din(mask_din),
        .ovf_clr(ovf_clr), .ir(ir_v[1]), .ir_id(id_v[1]), .in_service(svc_v[1]),
        .pending(pend_v[1]), .mask(mask_v[1]), .ovf(ovf_v[1]), .dbg_state(st_v[1])
    );

    // Reference model: mode 0 = idle, 1 = requesting, 2 = handler running.
    logic [7:0] m_pend[2], m_mask[2], m_ovf[2], m_prev[2];
    int         m_mode[2], m_id[2], m_rr[2];

    task automatic model_step(input int r);
        logic [7:0] el, novf;
        int nmode, nid, start, c;
        bit acc, rose, clr;
        if (!rst) begin
            m_mode[r] = 0; m_id[r] = 0; m_rr[r] = 0;
            m_pend[r] = 8'h00; m_ovf[r] = 8'h00; m_mask[r] = 8'h00;
            m_prev[r] = irq_in;
            return;
        end
        el    = ir_en ? (m_pend[r] & m_mask[r]) : 8'h00;
        novf  = 8'h00;
        acc   = 1'b0;
        nmode = m_mode[r];
        nid   = m_id[r];
        if (m_mode[r] == 0) begin
            start = (r == 1) ? m_rr[r] : 0;
            for (int k = 0; k < 8; k++) begin
                c = (start + k) % 8;
                if (el[c] && nmode == 0) begin
                    nmode = 1;
                    nid   = c;
                end
            end
        end else if (m_mode[r] == 1) begin
            if (!el[m_id[r]]) nmode = 0;
            else if (ir_ack && !stall) begin
                nmode = 2;
                acc   = 1'b1;
            end
        end else if (ir_done) begin
            nmode = 0;
        end
        for (int ch = 0; ch < 8; ch++) begin
            if (edge_chan[ch]) begin
                rose = irq_in[ch] && !m_prev[r][ch];
                clr  = acc && (m_id[r] == ch);
                if (rose && m_pend[r][ch] && !clr) novf[ch] = 1'b1;
                m_pend[r][ch] = rose || (m_pend[r][ch] && !clr);
            end else begin
                m_pend[r][ch] = irq_in[ch];
            end
        end
        m_ovf[r] = (ovf_clr ? 8'h00 : m_ovf[r]) | novf;
        if (mask_wen) m_mask[r] = mask_din;
        if (acc && r == 1) m_rr[r] = (m_id[r] + 1) % 8;
        m_mode[r] = nmode;
        m_id[r]   = nid;
        m_prev[r] = irq_in;
    endtask

    always @(posedge clk) begin
        for (int r = 0; r < 2; r++) model_step(r);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        irq_in = 8'h00; ir_en = 1'b1; stall = 1'b0; ir_ack = 1'b0; ir_done = 1'b0;
        mask_wen = 1'b0; mask_din = 8'h00; ovf_clr = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        mask_wen = 1'b1; mask_din = 8'hFF;
        cyc();
        mask_wen = 1'b0;
    endtask

    task automatic ack_and_done();
        ir_ack = 1'b1; cyc();
        ir_ack = 1'b0; ir_done = 1'b1; cyc();
        ir_done = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        cyc();
        for (int r = 0; r < 2; r++) begin
            total++;
            if ({ir_v[r], svc_v[r], id_v[r], pend_v[r], mask_v[r], ovf_v[r], st_v[r]} !== 30'd0) begin
                bad++;
                $display("FAIL reset dut=%0d got ir=%b svc=%b id=%0d pend=%h mask=%h ovf=%h want all zero",
                         r, ir_v[r], svc_v[r], id_v[r], pend_v[r], mask_v[r], ovf_v[r]);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_latency();
        do_reset();
        irq_in = 8'h20; cyc();
        for (int r = 0; r < 2; r++) begin
            total++;
            if (pend_v[r][5] !== 1'b1 || ir_v[r] !== 1'b0) begin
                bad++; $display("FAIL lat_pend dut=%0d got pend=%h ir=%b want pend[5]=1 ir=0", r, pend_v[r], ir_v[r]);
            end
        end
        irq_in = 8'h00; cyc();
        for (int r = 0; r < 2; r++) begin
            total++;
            if (ir_v[r] !== 1'b1 || id_v[r] !== 3'd5) begin
                bad++; $display("FAIL lat_ir dut=%0d got ir=%b id=%0d want ir=1 id=5", r, ir_v[r], id_v[r]);
            end
        end
        ir_ack = 1'b1; cyc();
        for (int r = 0; r < 2; r++) begin
            total++;
            if (svc_v[r] !== 1'b1 || ir_v[r] !== 1'b0 || pend_v[r][5] !== 1'b0) begin
                bad++; $display("FAIL lat_ack dut=%0d got svc=%b ir=%b pend=%h want svc=1 ir=0 pend[5]=0", r, svc_v[r], ir_v[r], pend_v[r]);
            end
        end
        ir_ack = 1'b0; ir_done = 1'b1; cyc();
        ir_done = 1'b0;
        for (int r = 0; r < 2; r++) begin
            total++;
            if (svc_v[r] !== 1'b0 || ir_v[r] !== 1'b0) begin
                bad++; $display("FAIL lat_done dut=%0d got svc=%b ir=%b want 0 0", r, svc_v[r], ir_v[r]);
            end
        end
    endtask

    task automatic test_priority();
        logic [2:0] want_first[2];
        logic [2:0] want_second[2];
        want_first[0] = 3'd2; want_first[1] = 3'd6;
        want_second[0] = 3'd6; want_second[1] = 3'd2;
        do_reset();
        // serve channel 2 alone so the round-robin pointer moves to 3
        irq_in = 8'h04; cyc();
        irq_in = 8'h00; cyc();
        ack_and_done();
        irq_in = 8'h44; cyc();
        irq_in = 8'h00; cyc();
        for (int r = 0; r < 2; r++) begin
            total++;
            if (ir_v[r] !== 1'b1 || id_v[r] !== want_first[r]) begin
                bad++; $display("FAIL prio_first dut=%0d got ir=%b id=%0d want ir=1 id=%0d", r, ir_v[r], id_v[r], want_first[r]);
            end
        end
        ack_and_done();
        cyc();
        for (int r = 0; r < 2; r++) begin
            total++;
            if (ir_v[r] !== 1'b1 || id_v[r] !== want_second[r]) begin
                bad++; $display("FAIL prio_second dut=%0d got ir=%b id=%0d want ir=1 id=%0d", r, ir_v[r], id_v[r], want_second[r]);
            end
        end
        ack_and_done();
    endtask

    task automatic test_stall();
        irq_in = 8'h08; cyc();
        irq_in = 8'h00; cyc();
        stall = 1'b1; ir_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            for (int r = 0; r < 2; r++) begin
                total++;
                if (ir_v[r] !== 1'b1 || id_v[r] !== 3'd3 || svc_v[r] !== 1'b0) begin
                    bad++; $display("FAIL stall_hold dut=%0d cyc=%0d got ir=%b id=%0d svc=%b want 1 3 0", r, i, ir_v[r], id_v[r], svc_v[r]);
                end
            end
        end
        stall = 1'b0; cyc();
        ir_ack = 1'b0;
        for (int r = 0; r < 2; r++) begin
            total++;
            if (svc_v[r] !== 1'b1 || ir_v[r] !== 1'b0) begin
                bad++; $display("FAIL stall_release dut=%0d got svc=%b ir=%b want 1 0", r, svc_v[r], ir_v[r]);
            end
        end
        ir_done = 1'b1; cyc();
        ir_done = 1'b0;
    endtask

    task automatic test_overflow();
        irq_in = 8'h02; cyc();
        irq_in = 8'h00; cyc();
        irq_in = 8'h02; cyc();
        for (int r = 0; r < 2; r++) begin
            total++;
            if (ovf_v[r] !== 8'h02 || pend_v[r][1] !== 1'b1) begin
                bad++; $display("FAIL ovf_set dut=%0d got ovf=%h pend=%h want ovf=02 pend[1]=1", r, ovf_v[r], pend_v[r]);
            end
        end
        irq_in = 8'h00; ovf_clr = 1'b1; cyc();
        for (int r = 0; r < 2; r++) begin
            total++;
            if (ovf_v[r] !== 8'h00 || pend_v[r][1] !== 1'b1) begin
                bad++; $display("FAIL ovf_clr dut=%0d got ovf=%h pend=%h want ovf=00 pend[1]=1", r, ovf_v[r], pend_v[r]);
            end
        end
        // overflow arriving together with the clear must survive
        irq_in = 8'h02; cyc();
        ovf_clr = 1'b0; irq_in = 8'h00;
        for (int r = 0; r < 2; r++) begin
            total++;
            if (ovf_v[r] !== 8'h02) begin
                bad++; $display("FAIL ovf_clr_race dut=%0d got ovf=%h want 02", r, ovf_v[r]);
            end
        end
        ovf_clr = 1'b1; cyc();
        ovf_clr = 1'b0; cyc();
        // edge on the channel being acked: set wins, no overflow
        irq_in = 8'h02; ir_ack = 1'b1; cyc();
        irq_in = 8'h00; ir_ack = 1'b0;
        for (int r = 0; r < 2; r++) begin
            total++;
            if (svc_v[r] !== 1'b1 || pend_v[r][1] !== 1'b1 || ovf_v[r] !== 8'h00) begin
                bad++; $display("FAIL set_wins dut=%0d got svc=%b pend=%h ovf=%h want 1 pend[1]=1 ovf=00", r, svc_v[r], pend_v[r], ovf_v[r]);
            end
        end
        ir_done = 1'b1; cyc();
        ir_done = 1'b0; cyc();
        for (int r = 0; r < 2; r++) begin
            total++;
            if (ir_v[r] !== 1'b1 || id_v[r] !== 3'd1) begin
                bad++; $display("FAIL set_wins_rereq dut=%0d got ir=%b id=%0d want 1 1", r, ir_v[r], id_v[r]);
            end
        end
        ack_and_done();
    endtask

    task automatic test_mask();
        irq_in = 8'h10; cyc();
        irq_in = 8'h00; cyc();
        mask_wen = 1'b1; mask_din = 8'hEF; cyc();
        mask_wen = 1'b0; cyc();
        for (int r = 0; r < 2; r++) begin
            total++;
            if (ir_v[r] !== 1'b0 || svc_v[r] !== 1'b0 || pend_v[r][4] !== 1'b1 || mask_v[r] !== 8'hEF) begin
                bad++; $display("FAIL mask_drop dut=%0d got ir=%b svc=%b pend=%h mask=%h want 0 0 pend[4]=1 EF", r, ir_v[r], svc_v[r], pend_v[r], mask_v[r]);
            end
        end
        mask_wen = 1'b1; mask_din = 8'hFF; cyc();
        mask_wen = 1'b0; cyc();
        for (int r = 0; r < 2; r++) begin
            total++;
            if (ir_v[r] !== 1'b1 || id_v[r] !== 3'd4) begin
                bad++; $display("FAIL mask_restore dut=%0d got ir=%b id=%0d want 1 4", r, ir_v[r], id_v[r]);
            end
        end
        ack_and_done();
    endtask

    task automatic test_level();
        irq_in = 8'h80; cyc();
        cyc();
        for (int r = 0; r < 2; r++) begin
            total++;
            if (ir_v[r] !== 1'b1 || id_v[r] !== 3'd7) begin
                bad++; $display("FAIL level_req dut=%0d got ir=%b id=%0d want 1 7", r, ir_v[r], id_v[r]);
            end
        end
        ir_ack = 1'b1; cyc();
        ir_ack = 1'b0;
        for (int r = 0; r < 2; r++) begin
            total++;
            if (svc_v[r] !== 1'b1 || pend_v[r][7] !== 1'b1) begin
                bad++; $display("FAIL level_ack dut=%0d got svc=%b pend=%h want svc=1 pend[7]=1", r, svc_v[r], pend_v[r]);
            end
        end
        ir_done = 1'b1; cyc();
        ir_done = 1'b0; cyc();
        irq_in = 8'h00; cyc();
        for (int r = 0; r < 2; r++) begin
            total++;
            if (pend_v[r][7] !== 1'b0 || ir_v[r] !== 1'b1) begin
                bad++; $display("FAIL level_drop dut=%0d got pend=%h ir=%b want pend[7]=0 ir=1", r, pend_v[r], ir_v[r]);
            end
        end
        cyc();
        for (int r = 0; r < 2; r++) begin
            total++;
            if (ir_v[r] !== 1'b0 || svc_v[r] !== 1'b0) begin
                bad++; $display("FAIL level_withdraw dut=%0d got ir=%b svc=%b want 0 0", r, ir_v[r], svc_v[r]);
            end
        end
    endtask

    task automatic test_reset_in_service();
        irq_in = 8'h01; cyc();
        irq_in = 8'h00; cyc();
        ir_ack = 1'b1; cyc();
        ir_ack = 1'b0;
        irq_in = 8'h08; cyc();
        rst = 1'b0; irq_in = 8'h01; cyc();
        rst = 1'b1;
        for (int r = 0; r < 2; r++) begin
            total++;
            if ({ir_v[r], svc_v[r], id_v[r], pend_v[r], mask_v[r], ovf_v[r]} !== 28'd0) begin
                bad++; $display("FAIL rst_service dut=%0d got ir=%b svc=%b id=%0d pend=%h mask=%h ovf=%h want all zero",
                                r, ir_v[r], svc_v[r], id_v[r], pend_v[r], mask_v[r], ovf_v[r]);
            end
        end
        mask_wen = 1'b1; mask_din = 8'hFF; cyc();
        mask_wen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            for (int r = 0; r < 2; r++) begin
                total++;
                if (pend_v[r] !== 8'h00 || ir_v[r] !== 1'b0) begin
                    bad++; $display("FAIL rst_no_edge dut=%0d got pend=%h ir=%b want 00 0", r, pend_v[r], ir_v[r]);
                end
            end
        end
        irq_in = 8'h00;
    endtask

    task automatic test_random();
        logic [7:0] v;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            for (int b = 0; b < 8; b++) v[b] = ($urandom_range(0, 4) == 0);
            irq_in   = v;
            ir_en    = ($urandom_range(0, 9) != 0);
            stall    = ($urandom_range(0, 3) == 0);
            ir_ack   = ($urandom_range(0, 1) == 0);
            ir_done  = ($urandom_range(0, 2) == 0);
            mask_wen = ($urandom_range(0, 15) == 0);
            mask_din = 8'($urandom);
            ovf_clr  = ($urandom_range(0, 7) == 0);
            rst      = ($urandom_range(0, 149) != 0);
            cyc();
            for (int r = 0; r < 2; r++) begin
                total++;
                if (ir_v[r] !== (m_mode[r] == 1) || svc_v[r] !== (m_mode[r] == 2) ||
                    id_v[r] !== 3'(m_id[r]) || pend_v[r] !== m_pend[r] ||
                    mask_v[r] !== m_mask[r] || ovf_v[r] !== m_ovf[r]) begin
                    bad++;
                    $display("FAIL random dut=%0d cyc=%0d got ir=%b svc=%b id=%0d pend=%h mask=%h ovf=%h want ir=%b svc=%b id=%0d pend=%h mask=%h ovf=%h",
                             r, i, ir_v[r], svc_v[r], id_v[r], pend_v[r], mask_v[r], ovf_v[r],
                             (m_mode[r] == 1), (m_mode[r] == 2), m_id[r], m_pend[r], m_mask[r], m_ovf[r]);
                end
            end
        end
        clear_inputs();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        cyc();
        test_reset();
        test_latency();
        test_priority();
        test_stall();
        test_overflow();
        test_mask();
        test_level();
        test_reset_in_service();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
